// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: ALU operations, ALU bus control, and sequencer state.
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_OP_NOT  = 4'd0,
        ALU_OP_ADD  = 4'd1,
        ALU_OP_SUB  = 4'd2,
        ALU_OP_AND  = 4'd3,
        ALU_OP_OR   = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SHL  = 4'd6,
        ALU_OP_LSHR = 4'd7,
        ALU_OP_ASHR = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_READ  = 2'd1,
        SEQ_WRITE = 2'd2
    } alu_seq_state_t;

    typedef struct packed {
        logic legal;
        logic uses_b;
        logic sets_v;
    } op_info_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request handshake between the instruction decoder (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
    parameter int REG_BITS = 2
);
    import alu_sequencer_pkg::*;

    logic                req_valid;
    logic                req_ready;
    alu_op_t             req_op;
    logic [REG_BITS-1:0] req_src_a;
    logic [REG_BITS-1:0] req_src_b;
    logic [REG_BITS-1:0] req_dst;
    logic                req_wb;

    modport master (
        output req_valid, req_op, req_src_a, req_src_b, req_dst, req_wb,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_src_a, req_src_b, req_dst, req_wb,
        output req_ready
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational classification of an ALU operation: legality, operand-B use, V-flag update.
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  alu_op_t  op,
    output op_info_t info
);
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        info = '{legal: 1'b0, uses_b: 1'b0, sets_v: 1'b0};
        unique case (op)
            ALU_OP_ADD, ALU_OP_SUB:
                info = '{legal: 1'b1, uses_b: 1'b1, sets_v: 1'b1};
            ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR:
                info = '{legal: 1'b1, uses_b: 1'b1, sets_v: 1'b0};
            ALU_OP_NOT, ALU_OP_SHL, ALU_OP_LSHR, ALU_OP_ASHR:
                info = '{legal: 1'b1, uses_b: 1'b0, sets_v: 1'b0};
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// Runs one ALU operation per accepted request: operand read, result write-back, Z/V flag update.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int REG_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_sequencer_if.slave      req,
    output logic [REG_BITS-1:0] rf_rd_a_addr,
    output logic [REG_BITS-1:0] rf_rd_b_addr,
    output logic                rf_wr_en,
    output logic [REG_BITS-1:0] rf_wr_addr,
    output alu_op_t             alu_mode,
    output reg_op_t             alu_control,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    output logic                flag_zero,
    output logic                flag_overflow,
    output logic                done,
    output logic                illegal_op
);
    if (WIDTH < 1 || REG_BITS < 1) begin : g_bad_param
        $error("alu_sequencer: WIDTH and REG_BITS must be at least 1");
    end

    alu_seq_state_t      state_q,    state_d;
    alu_op_t             op_q,       op_d;
    logic [REG_BITS-1:0] src_a_q,    src_a_d;
    logic [REG_BITS-1:0] src_b_q,    src_b_d;
    logic [REG_BITS-1:0] dst_q,      dst_d;
    logic                wb_q,       wb_d;
    logic                sets_v_q,   sets_v_d;
    logic                flag_z_q,   flag_z_d;
    logic                flag_v_q,   flag_v_d;
    logic                done_q,     done_d;
    logic                illegal_q,  illegal_d;
    op_info_t            req_info;

    alu_op_decode u_decode (
        .op   (req.req_op),
        .info (req_info)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        dst_d     = dst_q;
        wb_d      = wb_q;
        sets_v_d  = sets_v_q;
        flag_z_d  = flag_z_q;
        flag_v_d  = flag_v_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        req.req_ready = 1'b0;
        alu_control   = REG_OP_NONE;
        rf_wr_en      = 1'b0;

        unique case (state_q)
            SEQ_IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    if (req_info.legal) begin
                        op_d     = req.req_op;
                        src_a_d  = req.req_src_a;
                        // Unary ops park operand B on register 0 so the unused read is deterministic.
                        src_b_d  = req_info.uses_b ? req.req_src_b : '0;
                        dst_d    = req.req_dst;
                        wb_d     = req.req_wb;
                        sets_v_d = req_info.sets_v;
                        state_d  = SEQ_READ;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            SEQ_READ: begin
                alu_control = REG_OP_READ;
                state_d     = SEQ_WRITE;
            end
            SEQ_WRITE: begin
                alu_control = REG_OP_WRITE;
                rf_wr_en    = wb_q;
                flag_z_d    = alu_zero;
                // The ALU's carry line is only meaningful for ADD/SUB; other ops keep V.
                if (sets_v_q) flag_v_d = alu_overflow;
                done_d      = 1'b1;
                state_d     = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_IDLE;
            op_q      <= ALU_OP_NOT;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            wb_q      <= 1'b0;
            sets_v_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            dst_q     <= dst_d;
            wb_q      <= wb_d;
            sets_v_q  <= sets_v_d;
            flag_z_q  <= flag_z_d;
            flag_v_q  <= flag_v_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign rf_rd_a_addr  = src_a_q;
    assign rf_rd_b_addr  = src_b_q;
    assign rf_wr_addr    = dst_q;
    assign alu_mode      = op_q;
    assign flag_zero     = flag_z_q;
    assign flag_overflow = flag_v_q;
    assign done          = done_q;
    assign illegal_op    = illegal_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and negedge-capturing ALU.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int NVEC = 13;
    localparam logic [7:0] SENT = 8'hC3;

    logic       clk;
    logic       rst_n;
    logic [1:0] rf_rd_a_addr, rf_rd_b_addr, rf_wr_addr;
    logic       rf_wr_en, alu_zero, alu_overflow;
    logic       flag_zero, flag_overflow, done, illegal_op;
    alu_op_t    alu_mode;
    reg_op_t    alu_control;

    alu_sequencer_if #(.REG_BITS(2)) req_if ();

    alu_sequencer #(.WIDTH(8), .REG_BITS(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req_if),
        .rf_rd_a_addr  (rf_rd_a_addr),
        .rf_rd_b_addr  (rf_rd_b_addr),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .alu_mode      (alu_mode),
        .alu_control   (alu_control),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .flag_zero     (flag_zero),
        .flag_overflow (flag_overflow),
        .done          (done),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: write port driven by the sequencer, plus a bench preload port.
    logic [7:0] rf [4];
    logic       pl_en;
    logic [1:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [8:0] alu_wide;
    alu_op_t    alu_m;

    always @(posedge clk) begin
        if (rf_wr_en) rf[rf_wr_addr] <= alu_res;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    always @(negedge clk) begin
        if (alu_control == REG_OP_READ) begin
            alu_a <= rf[rf_rd_a_addr];
            alu_b <= rf[rf_rd_b_addr];
            alu_m <= alu_mode;
        end
    end

    always_comb begin
        alu_wide = '0;
        case (alu_m)
            ALU_OP_NOT:  alu_wide = {1'b0, ~alu_a};
            ALU_OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
            ALU_OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
            ALU_OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
            ALU_OP_SHL:  alu_wide = {1'b0, alu_a[6:0], 1'b0};
            ALU_OP_LSHR: alu_wide = {2'b00, alu_a[7:1]};
            ALU_OP_ASHR: alu_wide = {1'b0, alu_a[7], alu_a[7:1]};
            default:     alu_wide = '0;
        endcase
    end

    // Outside their valid windows the ALU status lines carry garbage (1).
    assign alu_res      = alu_wide[7:0];
    assign alu_zero     = (alu_control == REG_OP_WRITE) ? (alu_res == 8'h00) : 1'b1;
    assign alu_overflow = (alu_control == REG_OP_WRITE &&
                           (alu_m == ALU_OP_ADD || alu_m == ALU_OP_SUB)) ? alu_wide[8] : 1'b1;

    int wr_count = 0;
    int busy_count = 0;
    int viol_count = 0;
    always @(posedge clk) if (rf_wr_en) wr_count <= wr_count + 1;
    always @(negedge clk) begin
        if (alu_control != REG_OP_NONE) busy_count <= busy_count + 1;
        if (rf_wr_en && alu_control != REG_OP_WRITE) viol_count <= viol_count + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_addr = a;
        pl_data = v;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic present(input alu_op_t op, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [1:0] d, input logic wb);
        req_if.req_op    = op;
        req_if.req_src_a = sa;
        req_if.req_src_b = sb;
        req_if.req_dst   = d;
        req_if.req_wb    = wb;
        req_if.req_valid = 1'b1;
    endtask

    // Issues one request; lat = negedges after the accept edge until done (99 on timeout).
    task automatic run_op(input alu_op_t op, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] d, input logic wb, output int lat, output logic after);
        @(negedge clk);
        present(op, sa, sb, d, wb);
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        after = done;
    endtask

    typedef struct {
        alu_op_t    op;
        logic [1:0] sa, sb, d;
        logic       wb;
        logic [7:0] av, bv, res;
        logic       z, v;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic after;
        int   wr0, busy0, n, dones, idx;
        vec_t b2b [3];

        //            op           sa    sb    d     wb    a      b      result z     v (V held when not ADD/SUB)
        vecs[0]  = '{ALU_OP_ADD,  2'd0, 2'd1, 2'd2, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[1]  = '{ALU_OP_ADD,  2'd0, 2'd1, 2'd2, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{ALU_OP_AND,  2'd0, 2'd1, 2'd2, 1'b1, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{ALU_OP_SUB,  2'd0, 2'd1, 2'd2, 1'b0, 8'h05, 8'h05, SENT,  1'b1, 1'b0};
        vecs[4]  = '{ALU_OP_OR,   2'd3, 2'd1, 2'd0, 1'b1, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0};
        vecs[5]  = '{ALU_OP_SUB,  2'd1, 2'd3, 2'd2, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        vecs[6]  = '{ALU_OP_XOR,  2'd2, 2'd0, 2'd3, 1'b1, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{ALU_OP_NOT,  2'd0, 2'd1, 2'd3, 1'b1, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b1};
        vecs[8]  = '{ALU_OP_SHL,  2'd1, 2'd2, 2'd0, 1'b1, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
        vecs[9]  = '{ALU_OP_LSHR, 2'd2, 2'd3, 2'd1, 1'b1, 8'h81, 8'hFF, 8'h40, 1'b0, 1'b1};
        vecs[10] = '{ALU_OP_ASHR, 2'd3, 2'd0, 2'd2, 1'b1, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b1};
        vecs[11] = '{ALU_OP_ADD,  2'd0, 2'd1, 2'd2, 1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{ALU_OP_SUB,  2'd0, 2'd1, 2'd3, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req_if.req_valid = 1'b0; req_if.req_op = ALU_OP_NOT;
        req_if.req_src_a = '0; req_if.req_src_b = '0; req_if.req_dst = '0; req_if.req_wb = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("rst req_ready",   32'(req_if.req_ready), 1);
        check("rst rf_wr_en",    32'(rf_wr_en), 0);
        check("rst done",        32'(done), 0);
        check("rst illegal_op",  32'(illegal_op), 0);
        check("rst flag_zero",   32'(flag_zero), 0);
        check("rst flag_ovf",    32'(flag_overflow), 0);
        check("rst alu_control", 32'(alu_control), 32'(REG_OP_NONE));
        check("rst alu_mode",    32'(alu_mode), 32'(ALU_OP_NOT));
        check("rst addresses",   32'({rf_rd_a_addr, rf_rd_b_addr, rf_wr_addr}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            preload(vecs[i].sb, vecs[i].bv);
            preload(vecs[i].sa, vecs[i].av);
            preload(vecs[i].d, SENT);
            wr0 = wr_count;
            run_op(vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].d, vecs[i].wb, lat, after);
            check($sformatf("v%0d latency", i),   lat, 3);
            check($sformatf("v%0d done once", i), 32'(after), 0);
            check($sformatf("v%0d result", i),    32'(rf[vecs[i].d]), 32'(vecs[i].res));
            check($sformatf("v%0d flag_z", i),    32'(flag_zero), 32'(vecs[i].z));
            check($sformatf("v%0d flag_v", i),    32'(flag_overflow), 32'(vecs[i].v));
            check($sformatf("v%0d wr pulses", i), wr_count - wr0, 32'(vecs[i].wb));
        end

        // Back-to-back with req_valid held: op2 reads op1's dst, op3 reads op2's dst.
        preload(2'd0, 8'h10);
        preload(2'd1, 8'h20);
        preload(2'd3, 8'h05);
        b2b[0] = '{ALU_OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 8'h00, 8'h00, 8'h30, 1'b0, 1'b0};
        b2b[1] = '{ALU_OP_SUB, 2'd2, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b0};
        b2b[2] = '{ALU_OP_XOR, 2'd0, 2'd1, 2'd3, 1'b1, 8'h00, 8'h00, 8'h0B, 1'b0, 1'b0};
        @(negedge clk);
        present(b2b[0].op, b2b[0].sa, b2b[0].sb, b2b[0].d, b2b[0].wb);
        idx = 1; n = 0; dones = 0;
        while (dones < 3 && n < 30) begin
            @(negedge clk);
            n++;
            if (done) dones++;
            if (req_if.req_ready && idx < 3) begin
                present(b2b[idx].op, b2b[idx].sa, b2b[idx].sb, b2b[idx].d, b2b[idx].wb);
                idx++;
            end
        end
        req_if.req_valid = 1'b0;
        check("b2b cycles", n, 9);
        check("b2b dones", dones, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b op%0d result", i), 32'(rf[b2b[i].d]), 32'(b2b[i].res));
        check("b2b flag_z", 32'(flag_zero), 0);
        check("b2b flag_v", 32'(flag_overflow), 0);

        // Set Z=1, V=1, then an undefined op must leave everything untouched.
        preload(2'd0, 8'hFF);
        preload(2'd1, 8'h01);
        run_op(ALU_OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, lat, after);
        check("setup flag_z", 32'(flag_zero), 1);
        check("setup flag_v", 32'(flag_overflow), 1);
        wr0 = wr_count;
        busy0 = busy_count;
        @(negedge clk);
        present(alu_op_t'(4'hC), 2'd0, 2'd1, 2'd2, 1'b1);
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
        @(negedge clk);
        check("illegal pulse", 32'(illegal_op), 1);
        check("illegal ready", 32'(req_if.req_ready), 1);
        @(negedge clk);
        check("illegal one cycle", 32'(illegal_op), 0);
        repeat (3) @(negedge clk);
        check("illegal no busy",   busy_count - busy0, 0);
        check("illegal no write",  wr_count - wr0, 0);
        check("illegal flag_z",    32'(flag_zero), 1);
        check("illegal flag_v",    32'(flag_overflow), 1);
        check("illegal dst kept",  32'(rf[2]), 32'h00);
        check("illegal no done",   32'(done), 0);

        // Reset asserted during WRITE aborts the write-back and clears the flags.
        preload(2'd0, 8'h11);
        preload(2'd1, 8'h22);
        preload(2'd2, SENT);
        @(negedge clk);
        present(ALU_OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1);
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid wr_en before rst", 32'(rf_wr_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst wr_en",    32'(rf_wr_en), 0);
        check("mid rst control",  32'(alu_control), 32'(REG_OP_NONE));
        check("mid rst flag_z",   32'(flag_zero), 0);
        check("mid rst flag_v",   32'(flag_overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid rst dst kept", 32'(rf[2]), 32'(SENT));
        check("mid rst ready",    32'(req_if.req_ready), 1);
        check("mid rst no done",  32'(done), 0);
        run_op(ALU_OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, lat, after);
        check("recover latency", lat, 3);
        check("recover result",  32'(rf[2]), 32'h33);

        check("wr_en only in WRITE", viol_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
